// File: rtl/shift_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// shift_seq_pkg
// Shared types and helpers for the shift-amount sequencer.
//   state_t    : sequencer FSM states (IDLE, STEP, DWELL, DONE)
//   MODE_JUMP  : command mode, go straight to target
//   MODE_RAMP  : command mode, walk one step per tick toward target
//   div_f      : prescaler divide ratio CLK_INNER/FREQ_SHIFT (0 when invalid)
// ---------------------------------------------------------------------------
package shift_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STEP  = 2'd1,
        DWELL = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic MODE_JUMP = 1'b0;
    localparam logic MODE_RAMP = 1'b1;

    // Divide ratio; a non-positive rate yields 0 so the caller's range check fires.
    function automatic int div_f(input int clk_inner, input int freq_shift);
        if (freq_shift <= 0) begin
            return 0;
        end else begin
            return clk_inner / freq_shift;
        end
    endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// ---------------------------------------------------------------------------
// shift_sequencer_if
// Command handshake bundle for the shift sequencer.
//   cmd_valid  : requester offers a command
//   cmd_ready  : sequencer can accept (IDLE)
//   cmd_target : requested final shift amount
//   cmd_mode   : 0 = JUMP, 1 = RAMP
//   cmd_dwell  : ticks to hold at target before completion
// Modports: master (requester side), slave (sequencer side).
// ---------------------------------------------------------------------------
interface shift_sequencer_if #(
    parameter int AMT_W   = 3,
    parameter int DWELL_W = 8
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [AMT_W-1:0]   cmd_target;
    logic               cmd_mode;
    logic [DWELL_W-1:0] cmd_dwell;

    modport master (
        output cmd_valid, cmd_target, cmd_mode, cmd_dwell,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_target, cmd_mode, cmd_dwell,
        output cmd_ready
    );
endinterface

// File: rtl/shift_sequencer_tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen
// Prescaler: counts 0..DIV-1 and raises tick while the count is DIV-1, then
// wraps. clr restarts the count so the next tick lands DIV cycles later.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   clr  : synchronous count restart
//   tick : one-cycle step strobe
// ---------------------------------------------------------------------------
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_r;

    assign tick = (cnt_r == LAST);

    // Prescale counter with restart on command accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (clr || tick) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end
endmodule

// File: rtl/shift_sequencer.sv
// ---------------------------------------------------------------------------
// shift_sequencer
// Commandable sequencer for the shifter / barrel-shifter shift amount.
// Commands (target, JUMP/RAMP mode, dwell) arrive on a valid/ready bundle;
// ramps move one step per prescaled tick, then the target is held for
// `dwell` ticks before a one-cycle done pulse.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   cmd       : command handshake (shift_sequencer_if.slave)
//   shift_amt : registered shift amount to the datapath
//   shift_dir : registered, 1 = ramping up, 0 = ramping down / static
//   busy      : registered, high outside IDLE
//   done      : registered one-cycle completion pulse
// Build option: SHIFT_SEQ_AUTO_EN enables the legacy free-running
// increment of shift_amt while idle.
// ---------------------------------------------------------------------------
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int CLK_INNER  = 50_000_000,
    parameter int FREQ_SHIFT = 1_000,
    parameter int AMT_W      = 3,
    parameter int DWELL_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    shift_sequencer_if.slave   cmd,
    output logic [AMT_W-1:0]   shift_amt,
    output logic               shift_dir,
    output logic               busy,
    output logic               done
);
    localparam int DIV = div_f(CLK_INNER, FREQ_SHIFT);

    if (DIV < 1) begin : g_div_check
        $error("shift_sequencer: CLK_INNER/FREQ_SHIFT must be at least 1");
    end

    state_t             state_r;
    logic [AMT_W-1:0]   shift_amt_r;
    logic               shift_dir_r;
    logic               busy_r;
    logic               done_r;
    logic               cmd_ready_r;
    logic [AMT_W-1:0]   target_r;
    logic [DWELL_W-1:0] dwell_r;
    logic [DWELL_W-1:0] dwell_cnt_r;

    logic               tick_s;
    logic               accept_s;
    logic [AMT_W-1:0]   step_nxt_s;
    logic [DWELL_W-1:0] dwell_nxt_s;

    assign accept_s      = cmd.cmd_valid & cmd_ready_r;
    assign cmd.cmd_ready = cmd_ready_r;
    assign shift_amt     = shift_amt_r;
    assign shift_dir     = shift_dir_r;
    assign busy          = busy_r;
    assign done          = done_r;

    tick_gen #(.DIV(DIV)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept_s),
        .tick (tick_s)
    );

    // Next ramp position and dwell count including the current tick.
    always_comb begin
        step_nxt_s  = shift_amt_r;
        dwell_nxt_s = dwell_cnt_r + DWELL_W'(tick_s);
        if (shift_dir_r) begin
            step_nxt_s = shift_amt_r + AMT_W'(1);
        end else begin
            step_nxt_s = shift_amt_r - AMT_W'(1);
        end
    end

    // Sequencer FSM with registered datapath and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            shift_amt_r <= {AMT_W{1'b0}};
            shift_dir_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            cmd_ready_r <= 1'b1;
            target_r    <= {AMT_W{1'b0}};
            dwell_r     <= {DWELL_W{1'b0}};
            dwell_cnt_r <= {DWELL_W{1'b0}};
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        target_r    <= cmd.cmd_target;
                        dwell_r     <= cmd.cmd_dwell;
                        dwell_cnt_r <= {DWELL_W{1'b0}};
                        busy_r      <= 1'b1;
                        cmd_ready_r <= 1'b0;
                        if ((cmd.cmd_mode == MODE_JUMP) || (cmd.cmd_target == shift_amt_r)) begin
                            shift_amt_r <= cmd.cmd_target;
                            shift_dir_r <= 1'b0;
                            state_r     <= DWELL;
                        end else begin
                            shift_dir_r <= (cmd.cmd_target > shift_amt_r);
                            state_r     <= STEP;
                        end
                    end else begin
`ifdef SHIFT_SEQ_AUTO_EN
                        // Legacy free-run: wraps modulo 2^AMT_W by design.
                        if (tick_s) begin
                            shift_amt_r <= shift_amt_r + AMT_W'(1);
                            shift_dir_r <= 1'b1;
                        end else begin
                            shift_amt_r <= shift_amt_r;
                        end
`else
                        shift_amt_r <= shift_amt_r;
`endif
                    end
                end
                STEP: begin
                    // Direction always points at target, so the ramp cannot wrap.
                    if (tick_s) begin
                        shift_amt_r <= step_nxt_s;
                        if (step_nxt_s == target_r) begin
                            shift_dir_r <= 1'b0;
                            dwell_cnt_r <= {DWELL_W{1'b0}};
                            state_r     <= DWELL;
                        end else begin
                            state_r     <= STEP;
                        end
                    end else begin
                        state_r <= STEP;
                    end
                end
                DWELL: begin
                    // Compare the post-tick count so the final tick edge completes.
                    dwell_cnt_r <= dwell_nxt_s;
                    if (dwell_nxt_s == dwell_r) begin
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        state_r <= DWELL;
                    end
                end
                DONE: begin
                    busy_r      <= 1'b0;
                    cmd_ready_r <= 1'b1;
                    state_r     <= IDLE;
                end
                default: begin
                    busy_r      <= 1'b0;
                    cmd_ready_r <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shift_sequencer.sv
// ---------------------------------------------------------------------------
// tb_shift_sequencer
// Self-checking bench for shift_sequencer at CLK_INNER=8, FREQ_SHIFT=2
// (DIV=4), AMT_W=3. Expected per-cycle outputs are pushed to a scoreboard
// queue when a command is accepted and compared as the DUT produces them.
// Define SHIFT_SEQ_AUTO_EN to exercise the idle free-run wrap.
// ---------------------------------------------------------------------------
module tb_shift_sequencer;
    import shift_seq_pkg::*;

    localparam int AW   = 3;
    localparam int DW   = 8;
    localparam int DIVT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] shift_amt;
    logic          shift_dir;
    logic          busy;
    logic          done;

    shift_sequencer_if #(.AMT_W(AW), .DWELL_W(DW)) cmd_if ();

    shift_sequencer #(
        .CLK_INNER  (8),
        .FREQ_SHIFT (2),
        .AMT_W      (AW),
        .DWELL_W    (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd       (cmd_if),
        .shift_amt (shift_amt),
        .shift_dir (shift_dir),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int            cyc;
        logic [AW-1:0] amt;
        logic          dir_chk;
        logic          dir;
        logic          dn;
        logic          rdy;
    } exp_t;

    exp_t sb_q[$];

    function automatic void push(input int c, input int amt, input logic dir_chk,
                                 input logic dir, input logic dn, input logic rdy);
        exp_t e;
        e.cyc = c; e.amt = AW'(amt); e.dir_chk = dir_chk;
        e.dir = dir; e.dn = dn; e.rdy = rdy;
        sb_q.push_back(e);
    endfunction

    // Reference model: expected trajectory for a command accepted at edge e.
    function automatic void expect_cmd(input int e, input int start, input int tgt,
                                       input logic mode, input int dwell);
        int   n;
        int   l;
        int   dd;
        int   step;
        logic up;
        up   = (tgt > start);
        step = up ? 1 : -1;
        n    = (mode == MODE_RAMP && tgt != start) ? (up ? tgt - start : start - tgt) : 0;
        if (n == 0) push(e, tgt, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= n; k++) begin
            push(e + DIVT*k - 1, start + step*(k-1), 1'b1, up, 1'b0, 1'b0);
            push(e + DIVT*k,     start + step*k,     (k < n), up, 1'b0, 1'b0);
        end
        l  = e + DIVT*n;
        dd = (dwell > 0) ? l + DIVT*dwell : l + 1;
        push(dd - 1, tgt, 1'b0, 1'b0, 1'b0, 1'b0);
        push(dd,     tgt, 1'b0, 1'b0, 1'b1, 1'b0);
        push(dd + 1, tgt, 1'b0, 1'b0, 1'b0, 1'b1);
    endfunction

    // Offer a command and hold it until accepted; e = cycle index after the accept edge.
    task automatic send_cmd(input int t, input logic m, input int d, output int e);
        logic rdy;
        e = -1;
        @(negedge clk);
        cmd_if.cmd_target = AW'(t);
        cmd_if.cmd_mode   = m;
        cmd_if.cmd_dwell  = DW'(d);
        cmd_if.cmd_valid  = 1'b1;
        for (int n = 0; n < 64; n++) begin
            rdy = cmd_if.cmd_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                e = cyc;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        checks++;
        if (e < 0) begin
            errors++;
            $display("FAIL accept_timeout: accepted=%0d required=1", 0);
        end
    endtask

    // Pop and compare scoreboard entries as their cycle comes up.
    task automatic drain(input string tag, input int budget);
        exp_t e;
        int   n;
        n = 0;
        while (sb_q.size() > 0 && n < budget) begin
            while (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
                e = sb_q.pop_front();
                checks++;
                if (shift_amt !== e.amt) begin
                    errors++;
                    $display("FAIL %s_amt cyc=%0d: got %0d want %0d", tag, cyc, shift_amt, e.amt);
                end
                if (e.dir_chk) begin
                    checks++;
                    if (shift_dir !== e.dir) begin
                        errors++;
                        $display("FAIL %s_dir cyc=%0d: got %0b want %0b", tag, cyc, shift_dir, e.dir);
                    end
                end
                checks++;
                if (done !== e.dn) begin
                    errors++;
                    $display("FAIL %s_done cyc=%0d: got %0b want %0b", tag, cyc, done, e.dn);
                end
                checks++;
                if (cmd_if.cmd_ready !== e.rdy) begin
                    errors++;
                    $display("FAIL %s_ready cyc=%0d: got %0b want %0b", tag, cyc, cmd_if.cmd_ready, e.rdy);
                end
            end
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb_q.size() > 0) begin
            errors++;
            $display("FAIL %s_timeout: pending=%0d want 0", tag, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({shift_amt, shift_dir, busy, done, cmd_if.cmd_ready} !== {3'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset: got amt=%0d dir=%0b busy=%0b done=%0b rdy=%0b want 0/0/0/0/1",
                     shift_amt, shift_dir, busy, done, cmd_if.cmd_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_jump();
        int e;
        send_cmd(5, MODE_JUMP, 0, e);
        expect_cmd(e, 0, 5, MODE_JUMP, 0);
        drain("jump", 40);
        send_cmd(4, MODE_JUMP, 1, e);
        expect_cmd(e, 5, 4, MODE_JUMP, 1);
        drain("jump_dwell", 40);
    endtask

    task automatic test_ramp_up();
        int e;
        send_cmd(0, MODE_JUMP, 0, e);
        expect_cmd(e, 4, 0, MODE_JUMP, 0);
        drain("ramp_up_pre", 40);
        send_cmd(3, MODE_RAMP, 2, e);
        expect_cmd(e, 0, 3, MODE_RAMP, 2);
        drain("ramp_up", 80);
    endtask

    task automatic test_ramp_down();
        int e;
        send_cmd(6, MODE_JUMP, 0, e);
        expect_cmd(e, 0, 6, MODE_JUMP, 0);
        drain("ramp_dn_pre", 40);
        send_cmd(2, MODE_RAMP, 0, e);
        expect_cmd(e, 6, 2, MODE_RAMP, 0);
        drain("ramp_dn", 80);
    endtask

    task automatic test_back_to_back();
        int ea;
        int acc;
        int dn_a;
        int dn_b;
        send_cmd(1, MODE_JUMP, 0, ea);
        checks++;
        if (shift_amt !== 3'd1) begin
            errors++;
            $display("FAIL b2b_first_amt: got %0d want 1", shift_amt);
        end
        cmd_if.cmd_target = 3'd6;
        cmd_if.cmd_mode   = MODE_JUMP;
        cmd_if.cmd_dwell  = 8'd0;
        cmd_if.cmd_valid  = 1'b1;
        acc  = -1;
        dn_a = 0;
        for (int n = 0; n < 20; n++) begin
            if (done) dn_a++;
            if (cmd_if.cmd_ready) begin
                @(posedge clk);
                #1;
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        checks++;
        if (acc !== ea + 3) begin
            errors++;
            $display("FAIL b2b_accept_cycle: got %0d want %0d", acc - ea, 3);
        end
        checks++;
        if (dn_a !== 1) begin
            errors++;
            $display("FAIL b2b_first_done_count: got %0d want 1", dn_a);
        end
        checks++;
        if (shift_amt !== 3'd6) begin
            errors++;
            $display("FAIL b2b_second_amt: got %0d want 6", shift_amt);
        end
        dn_b = 0;
        for (int n = 0; n < 12; n++) begin
            if (done) dn_b++;
            @(negedge clk);
        end
        checks++;
        if (dn_b !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second_done: got count=%0d busy=%0b want 1/0", dn_b, busy);
        end
    endtask

    task automatic test_reset_mid();
        int e;
        int dn_cnt;
        int moved;
        send_cmd(0, MODE_JUMP, 0, e);
        expect_cmd(e, 6, 0, MODE_JUMP, 0);
        drain("mid_pre", 40);
        send_cmd(5, MODE_RAMP, 0, e);
        while (cyc < e + 2*DIVT) @(negedge clk);
        checks++;
        if (shift_amt !== 3'd2) begin
            errors++;
            $display("FAIL mid_before_rst: got %0d want 2", shift_amt);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({shift_amt, shift_dir, busy, done, cmd_if.cmd_ready} !== {3'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL mid_rst_state: got amt=%0d dir=%0b busy=%0b done=%0b rdy=%0b want 0/0/0/0/1",
                     shift_amt, shift_dir, busy, done, cmd_if.cmd_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        dn_cnt = 0;
        moved  = 0;
        for (int n = 0; n < 40; n++) begin
            if (done) dn_cnt++;
            if (shift_amt !== 3'd0) moved++;
            @(negedge clk);
        end
        checks++;
        if (dn_cnt !== 0) begin
            errors++;
            $display("FAIL mid_no_done: got %0d pulses want 0", dn_cnt);
        end
        checks++;
        if (moved !== 0) begin
            errors++;
            $display("FAIL idle_hold: got %0d moved cycles want 0", moved);
        end
    endtask

`ifdef SHIFT_SEQ_AUTO_EN
    task automatic test_auto();
        int r;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        r = cyc;
        @(negedge clk);
        rst = 1'b0;
        while (cyc < r + 7*DIVT) @(negedge clk);
        checks++;
        if (shift_amt !== 3'd7 || shift_dir !== 1'b1) begin
            errors++;
            $display("FAIL auto_top: got amt=%0d dir=%0b want 7/1", shift_amt, shift_dir);
        end
        while (cyc < r + 8*DIVT - 1) @(negedge clk);
        checks++;
        if (shift_amt !== 3'd7) begin
            errors++;
            $display("FAIL auto_hold: got %0d want 7", shift_amt);
        end
        @(negedge clk);
        checks++;
        if (shift_amt !== 3'd0) begin
            errors++;
            $display("FAIL auto_wrap: got %0d want 0", shift_amt);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_if.cmd_valid  = 1'b0;
        cmd_if.cmd_target = 3'd0;
        cmd_if.cmd_mode   = MODE_JUMP;
        cmd_if.cmd_dwell  = 8'd0;
        test_reset();
        test_jump();
`ifdef SHIFT_SEQ_AUTO_EN
        test_auto();
`else
        test_ramp_up();
        test_ramp_down();
        test_back_to_back();
        test_reset_mid();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Controller that sequences the shift amount of the downstream shifter/barrel shifter datapath.
- Accepts commands over a valid/ready handshake. Each command carries a target amount, a mode (jump or ramp) and a dwell time.
- Drives the shift amount at a prescaled step rate derived from CLK_INNER/FREQ_SHIFT.
- Replaces the free-running shift-amount generator with a commandable sequencer.

Parameters:
CLK_INNER, 50_000_000, internal clock frequency in Hz
FREQ_SHIFT, 1_000, step/tick rate in Hz. DIV = CLK_INNER/FREQ_SHIFT; DIV < 1 is an elaboration error.
AMT_W, 3, shift-amount width (2 = shifter, 3 = barrel shifter)
DWELL_W, 8, dwell-count width, in ticks

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  block can accept a command
cmd_target  in  AMT_W  requested final shift amount
cmd_mode  in  1  0 = JUMP, 1 = RAMP
cmd_dwell  in  DWELL_W  ticks to hold at target before completion
shift_amt  out  AMT_W  shift amount to datapath, registered
shift_dir  out  1  1 = ramping up, 0 = ramping down/static, registered
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle completion pulse

Behaviour:
- Clock/reset (already decided): one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values, applied at the first edge with rst=1: shift_amt=0, shift_dir=0, busy=0, done=0, cmd_ready=1, state=IDLE, prescaler=0, dwell counter=0.
- Prescaler:
  - Counts 0..DIV-1 and asserts tick for one cycle when count==DIV-1, then wraps to 0.
  - Counter width is max(1, $clog2(DIV)).
  - Cleared to 0 on command accept, so the first tick arrives exactly DIV cycles after accept.
- Handshake:
  - Accept occurs at an edge with cmd_valid & cmd_ready. Target, mode and dwell are latched at that edge.
  - cmd_ready = (state==IDLE).
  - The requester must hold cmd_valid and the command fields until accepted. Inputs are ignored while busy.
- FSM states: IDLE, STEP, DWELL, DONE.
  - IDLE, on accept:
    - JUMP mode, or target==shift_amt: shift_amt<=target; go DWELL.
    - RAMP mode with target!=shift_amt: shift_dir<=(target>shift_amt); go STEP.
  - STEP: on tick, shift_amt moves by ±1 toward target. The step that lands on target moves the FSM to DWELL with dwell counter=0.
  - DWELL: the counter increments on each tick. When counter==dwell (checked every cycle), go DONE. dwell=0 means DONE on the very next edge.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Arithmetic: ramps never wrap modulo 2^AMT_W; movement is strictly monotonic toward target. shift_amt is unchanged by DWELL/DONE.
- Latency, JUMP with dwell=0:
  - shift_amt is valid after the accept edge E.
  - done is high between E+1 and E+2.
  - cmd_ready returns after E+2.
- Simultaneous tick and state-entry edge: a tick on the accept edge is discarded (prescaler cleared).
- Reset mid-operation: the next edge forces reset values. The in-flight command is dropped and no done pulse is produced.

Optional Feature:
SHIFT_SEQ_AUTO_EN.
- Defined: in IDLE with no accept, shift_amt increments by 1 on each tick, wrapping 2^AMT_W-1 -> 0, with shift_dir=1. This is the legacy free-run pattern. An accept pre-empts the free-run at once, and the prescaler is cleared.
- Undefined: shift_amt holds its value in IDLE and the prescaler free-runs with no effect.

Decomposition:
- Package shift_seq_pkg contains:
  - state_t enum (IDLE, STEP, DWELL, DONE);
  - MODE_JUMP=1'b0, MODE_RAMP=1'b1;
  - a div_f function for CLK_INNER/FREQ_SHIFT with the range check.
- Sub-module tick_gen:
  - ports clk, rst, clr, tick;
  - parameter DIV;
  - implements the prescaler.
- FSM and datapath live in shift_sequencer.

Test Plan (CLK_INNER=8, FREQ_SHIFT=2 -> DIV=4, AMT_W=3):
1. rst=1 for 2 cycles -> shift_amt=0, shift_dir=0, busy=0, done=0, cmd_ready=1.
2. JUMP target=5, dwell=0, accepted at edge E -> shift_amt=5 after E; done high only in cycle E+1..E+2; cmd_ready=1 after E+2.
3. RAMP 0->3, dwell=2, accepted at E -> shift_amt=1,2,3 after E+4, E+8, E+12; shift_dir=1; done high in cycle E+20..E+21.
4. Start at 6, RAMP target=2, dwell=0 -> shift_dir=0; shift_amt=5,4,3,2 at +4/+8/+12/+16; never wraps through 7 or 0.
5. cmd_valid held high with a second command during busy -> cmd_ready=0 throughout; second command accepted on the first IDLE edge after done; no command lost or duplicated.
6. rst pulsed mid-ramp at shift_amt=2 -> shift_amt=0 after that edge; no done pulse. With SHIFT_SEQ_AUTO_EN defined and idle: 7 -> 0 wrap on tick.
